mult32x32_sched: RTL and testbench
==================================

Name: mult32x32_sched

Overview:
- Round-robin scheduler that shares one iterative 32x32 multiplier (start/busy/product interface) among NUM_REQ requesters.
- Accepts operand pairs over a req/gnt handshake and issues a one-cycle start to the multiplier.
- Holds the operands stable for the whole multiply, captures the 64-bit product when busy falls, and returns it with a per-requester done pulse.
- Sits between client blocks and the multiplier top level. It is the only driver of the multiplier's start, a and b.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACC_TIMEOUT, 4, max cycles to wait for mul_busy to rise after start before flagging an error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request; held high with operands stable until gnt.
- a_in  input  NUM_REQ*32  operand a, requester i at bits [32*i+31:32*i].
- b_in  input  NUM_REQ*32  operand b, same packing as a_in.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: operands of requester i accepted.
- done  output  NUM_REQ  one-hot, one-cycle pulse: result valid for requester i.
- result  output  64  product of the last completed operation; held until the next completion.
- err  output  1  one-cycle pulse with done when ACC_TIMEOUT expired.
- sched_busy  output  1  high in every state except IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the requester currently being served.
- mul_start  output  1  start to multiplier.
- mul_a  output  32  operand a to multiplier.
- mul_b  output  32  operand b to multiplier.
- mul_busy  input  1  multiplier busy.
- mul_product  input  64  multiplier product.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, grant_id=0, all outputs 0 (gnt, done, err, result, mul_start, mul_a, mul_b, sched_busy). A reset mid-operation drops the op: no done, no err.
- FSM states: IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP.
- IDLE:
  - If any req is high, select the first requester at or after rr_ptr (wrapping modulo NUM_REQ).
  - Register mul_a/mul_b from that requester's slice and set grant_id; next state ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle): mul_start=1, gnt[grant_id]=1, rr_ptr <= grant_id+1 (wraps to 0 after NUM_REQ-1). Next state WAIT_ACC.
- WAIT_ACC:
  - mul_busy=1 -> WAIT_DONE.
  - Otherwise count; when the count reaches ACC_TIMEOUT, set err_flag and go to RESP.
- WAIT_DONE: stay while mul_busy=1; on mul_busy=0 -> RESP.
- RESP (1 cycle):
  - result <= mul_product (registered; visible from the cycle after RESP).
  - done[grant_id] pulses the cycle after RESP; err pulses in the same cycle if err_flag is set.
  - Clear err_flag; next state IDLE.
- Operand hold: mul_a/mul_b change only in IDLE. They stay stable from ISSUE through RESP because the multiplier reads its operands on every iteration.
- mul_start is high only in ISSUE, never in back-to-back cycles.
- Requester withdrawal:
  - A req deasserted before IDLE samples it is ignored.
  - A req deasserted after IDLE selection still completes; the requester receives done.
- Overlap: a requester may reassert req in the cycle after gnt; it is queued behind the others by round-robin.
- Latency, req high in idle state at edge t:
  - gnt and mul_start at t+1.
  - done = t + 3 + N, where N = number of cycles mul_busy is high.
  - Minimum turnaround between consecutive ops: 2 idle/issue cycles plus the multiply.
- Fairness: every requester holding req is granted within NUM_REQ operations.
- Simultaneous events: all req high -> requesters granted in order rr_ptr, rr_ptr+1, ...; a new req arriving during WAIT_DONE waits for IDLE.

Test Plan:
- Single op: reset, req[0], a=0x0000_0003, b=0x0000_0005 -> one gnt[0] pulse, one mul_start, result=0x0000_0000_0000_000F with done[0]; mul_a/mul_b stable while mul_busy is high.
- Max operands: req[2], a=b=0xFFFF_FFFF -> result=0xFFFF_FFFE_0000_0001, done[2] only, err=0.
- Contention: req[0..3] all high with distinct operands -> grants in order 0,1,2,3, then 0 again if req[0] is re-held; each done carries the correct product; no overlapping mul_start.
- Timeout: multiplier model never raises busy -> err and done[grant_id] pulse together ACC_TIMEOUT cycles after the WAIT_ACC count starts; FSM returns to IDLE and serves the next request.
- Reset mid-op: assert reset during WAIT_DONE -> all outputs 0 immediately, no done; after release, req[1] is served first (rr_ptr=0, no req[0]).
- Withdrawal: req[3] pulsed for 0 cycles at idle sample while req[1] is held -> only requester 1 is granted.

Source files
------------

// File: rtl/mult32x32_sched.sv
// Round-robin scheduler that shares one iterative 32x32 multiplier among
// NUM_REQ requesters. It grants one operand pair at a time, holds the operands
// for the whole multiply and returns the product with a per-requester done.
module mult32x32_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ACC_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*32-1:0]      a_in,
  input  logic [NUM_REQ*32-1:0]      b_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [63:0]                result,
  output logic                       err,
  output logic                       sched_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       mul_start,
  output logic [31:0]                mul_a,
  output logic [31:0]                mul_b,
  input  logic                       mul_busy,
  input  logic [63:0]                mul_product
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACC_TIMEOUT + 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACC,
    WAIT_DONE,
    RESP
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] acc_cnt;
  logic             err_flag;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;

  // Requester index k positions after base, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin pick: scanning from the far end lets the requester closest to rr_ptr win.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_ptr, k)]) begin
        pick_valid = 1'b1;
        pick_id    = wrap_add(rr_ptr, k);
      end
    end
  end

  // Scheduler FSM; every output is a register so pulses are glitch-free for the clients.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      acc_cnt    <= '0;
      err_flag   <= 1'b0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      result     <= '0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      sched_busy <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            mul_a        <= a_in[32*pick_id +: 32];
            mul_b        <= b_in[32*pick_id +: 32];
            grant_id     <= pick_id;
            gnt[pick_id] <= 1'b1;
            mul_start    <= 1'b1;
            sched_busy   <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          rr_ptr  <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
          acc_cnt <= '0;
          state   <= WAIT_ACC;
        end
        WAIT_ACC: begin
          if (mul_busy) begin
            state <= WAIT_DONE;
          end else if (acc_cnt == CNT_LAST) begin
            err_flag <= 1'b1;
            state    <= RESP;
          end else begin
            acc_cnt <= acc_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!mul_busy) state <= RESP;
        end
        RESP: begin
          result         <= mul_product;
          done[grant_id] <= 1'b1;
          err            <= err_flag;
          err_flag       <= 1'b0;
          sched_busy     <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult32x32_sched.sv
// Testbench for mult32x32_sched: a behavioural multiplier, a queue-based
// scoreboard with its own round-robin model, and directed plus random steps.
module tb_mult32x32_sched;

  localparam int NUM_REQ     = 4;
  localparam int ACC_TIMEOUT = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] a_in;
  logic [NUM_REQ*32-1:0] b_in;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [63:0]           result;
  logic                  err;
  logic                  sched_busy;
  logic [1:0]            grant_id;
  logic                  mul_start;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic                  mul_busy;
  logic [63:0]           mul_product = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          busy_len = 2;
  bit          no_ack = 1'b0;
  logic [31:0] opa, opb;
  int          mcnt;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          cyc;
    int          lat;
    logic        err;
  } op_t;

  op_t              q[$];
  op_t              e;
  int               model_ptr = 0;
  logic [NUM_REQ-1:0] req_prev = '0;
  logic             prev_start = 1'b0;
  int               m_gid, m_exp, m_did;
  int               exp_order[5] = '{0, 1, 2, 3, 0};

  mult32x32_sched #(.NUM_REQ(NUM_REQ), .ACC_TIMEOUT(ACC_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .sched_busy(sched_busy), .grant_id(grant_id), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: busy for busy_len cycles after start, product appears as busy falls.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_busy <= 1'b0;
      mcnt     <= 0;
    end else if (mul_start && !no_ack) begin
      mul_busy <= 1'b1;
      mcnt     <= busy_len;
      opa      <= mul_a;
      opb      <= mul_b;
    end else if (mul_busy) begin
      if (mcnt <= 1) begin
        mul_busy    <= 1'b0;
        mul_product <= 64'(opa) * 64'(opb);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: round-robin order model, operand hold, products, err and latency.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      model_ptr  = 0;
      req_prev   = '0;
      prev_start = 1'b0;
    end else begin
      if (gnt != '0) begin
        check_output("gnt_onehot", 64'($onehot0(gnt)), 64'd1);
        m_gid = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (gnt[k]) m_gid = k;
        m_exp = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--)
          if (req_prev[(model_ptr + k) % NUM_REQ]) m_exp = (model_ptr + k) % NUM_REQ;
        check_output("gnt_order", 64'(m_gid), 64'(m_exp));
        check_output("gnt_overlap", 64'(q.size()), 64'd0);
        check_output("grant_id", 64'(grant_id), 64'(m_gid));
        check_output("gnt_with_start", 64'(mul_start), 64'd1);
        check_output("gnt_sched_busy", 64'(sched_busy), 64'd1);
        e.id   = m_gid;
        e.a    = a_in[32*m_gid +: 32];
        e.b    = b_in[32*m_gid +: 32];
        e.prod = 64'(e.a) * 64'(e.b);
        e.cyc  = cyc;
        e.err  = no_ack;
        e.lat  = no_ack ? ACC_TIMEOUT + 2 : busy_len + 3;
        check_output("mul_a_issue", 64'(mul_a), 64'(e.a));
        check_output("mul_b_issue", 64'(mul_b), 64'(e.b));
        q.push_back(e);
        model_ptr = (m_gid + 1) % NUM_REQ;
      end else if (mul_start) begin
        check_output("start_without_gnt", 64'(mul_start), 64'd0);
      end
      if (mul_start && prev_start) check_output("start_back_to_back", 64'(mul_start), 64'd0);
      prev_start = mul_start;
      if (mul_busy && q.size() > 0) begin
        check_output("mul_a_hold", 64'(mul_a), 64'(q[0].a));
        check_output("mul_b_hold", 64'(mul_b), 64'(q[0].b));
      end
      if (done != '0) begin
        check_output("done_onehot", 64'($onehot0(done)), 64'd1);
        m_did = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (done[k]) m_did = k;
        if (q.size() == 0) begin
          check_output("done_unexpected", 64'(done), 64'd0);
        end else begin
          e = q.pop_front();
          check_output("done_id", 64'(m_did), 64'(e.id));
          check_output("done_result", result, e.err ? mul_product : e.prod);
          check_output("done_err", 64'(err), 64'(e.err));
          check_output("done_latency", 64'(cyc - e.cyc), 64'(e.lat));
        end
      end else if (err) begin
        check_output("err_without_done", 64'(err), 64'd0);
      end
      req_prev = req;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int id, input logic [31:0] a, input logic [31:0] b);
    req[id]          = 1'b1;
    a_in[32*id +: 32] = a;
    b_in[32*id +: 32] = b;
  endtask

  task automatic wait_any_gnt(output int id);
    id = -1;
    for (int k = 0; k < 64 && id < 0; k++) begin
      @(negedge clk);
      for (int i = NUM_REQ - 1; i >= 0; i--) if (gnt[i]) id = i;
    end
    check_output("gnt_wait", 64'(id >= 0), 64'd1);
  endtask

  task automatic serve_gnt(input int id);
    bit seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (gnt[id]) seen = 1'b1;
    end
    check_output("gnt_wait", 64'(seen), 64'd1);
    sync();
    req[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    bit seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (done[id]) seen = 1'b1;
    end
    check_output("done_wait", 64'(seen), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_gnt", 64'(gnt), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_result", result, 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_mul_start", 64'(mul_start), 64'd0);
    check_output("rst_mul_a", 64'(mul_a), 64'd0);
    check_output("rst_mul_b", 64'(mul_b), 64'd0);
    check_output("rst_sched_busy", 64'(sched_busy), 64'd0);
    check_output("rst_grant_id", 64'(grant_id), 64'd0);
  endtask

  // Safety net against a hung design.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed steps followed by random batches.
  initial begin
    int gid;
    int last;
    int cnt;
    logic [3:0] mask;
    reset = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    #3;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] single operation");
    sync();
    busy_len = 3;
    apply_stimulus(0, 32'h0000_0003, 32'h0000_0005);
    serve_gnt(0);
    wait_done(0);
    check_output("single_result", result, 64'h0000_0000_0000_000F);
    check_output("single_done", 64'(done), 64'b0001);
    @(negedge clk);
    check_output("idle_sched_busy", 64'(sched_busy), 64'd0);

    $display("[TB] max operands");
    sync();
    busy_len = 5;
    apply_stimulus(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    serve_gnt(2);
    wait_done(2);
    check_output("max_result", result, 64'hFFFF_FFFE_0000_0001);
    check_output("max_done", 64'(done), 64'b0100);
    check_output("max_err", 64'(err), 64'd0);

    sync();
    busy_len = 1;
    apply_stimulus(3, $urandom, $urandom);
    serve_gnt(3);
    wait_done(3);

    $display("[TB] contention");
    sync();
    busy_len = 2;
    for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, $urandom, $urandom);
    for (int step = 0; step < 5; step++) begin
      wait_any_gnt(gid);
      check_output("contention_order", 64'(gid), 64'(exp_order[step]));
      sync();
      if (gid >= 0) req[gid] = 1'b0;
      if (step == 0) apply_stimulus(0, $urandom, $urandom);
    end
    wait_done(0);

    $display("[TB] accept timeout");
    sync();
    no_ack = 1'b1;
    apply_stimulus(1, $urandom, $urandom);
    serve_gnt(1);
    apply_stimulus(2, $urandom, $urandom);
    wait_done(1);
    check_output("timeout_err", 64'(err), 64'd1);
    no_ack = 1'b0;
    serve_gnt(2);
    wait_done(2);
    check_output("after_timeout_err", 64'(err), 64'd0);

    $display("[TB] reset during multiply");
    sync();
    busy_len = 8;
    apply_stimulus(2, $urandom, $urandom);
    serve_gnt(2);
    @(negedge clk);
    @(negedge clk);
    check_output("pre_reset_busy", 64'(sched_busy), 64'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    sync();
    sync();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_output("no_done_after_reset", 64'(done), 64'd0);
    end
    sync();
    busy_len = 2;
    apply_stimulus(1, $urandom, $urandom);
    apply_stimulus(3, $urandom, $urandom);
    wait_any_gnt(gid);
    check_output("post_reset_first", 64'(gid), 64'd1);
    sync();
    req[1] = 1'b0;
    wait_any_gnt(gid);
    check_output("post_reset_second", 64'(gid), 64'd3);
    sync();
    req[3] = 1'b0;
    wait_done(3);

    $display("[TB] withdrawal");
    sync();
    apply_stimulus(1, $urandom, $urandom);
    req[3] = 1'b1;
    #1 req[3] = 1'b0;
    wait_any_gnt(gid);
    check_output("withdraw_grant", 64'(gid), 64'd1);
    sync();
    req[1] = 1'b0;
    wait_done(1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("withdraw_no_gnt", 64'(gnt), 64'd0);
    end

    $display("[TB] random batches");
    for (int r = 0; r < 12; r++) begin
      sync();
      busy_len = $urandom_range(1, 5);
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) if (mask[i]) apply_stimulus(i, $urandom, $urandom);
      cnt  = $countones(mask);
      last = -1;
      for (int k = 0; k < cnt; k++) begin
        wait_any_gnt(gid);
        sync();
        if (gid >= 0) begin
          req[gid] = 1'b0;
          last = gid;
        end
      end
      if (last >= 0) wait_done(last);
    end

    sync();
    sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
